// File: rtl/patient_admit.sv
// Admission stage ahead of the patient priority queue: allocates one of four
// patient IDs, holds the {severity, id} token until the queue has room, and ages stalled tokens.
module patient_admit #(
    parameter int AGE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_arr_valid,
    input  logic [1:0] i_arr_sev,
    output logic       o_arr_ready,
    input  logic       i_q_full,
    output logic       o_enq_valid,
    output logic [3:0] o_enq_data,
    input  logic       i_rel_valid,
    input  logic [1:0] i_rel_id,
    output logic [3:0] o_busy_ids,
    output logic [2:0] o_free_cnt,
    output logic       o_rel_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [7:0] AGE_LAST = 8'(AGE_LIMIT - 1);

    state_t     r_state;
    logic [1:0] r_sev;
    logic [1:0] r_id;
    logic [7:0] r_wait_cnt;
    logic       r_enq_valid;
    logic [3:0] r_enq_data;
    logic [3:0] r_busy;
    logic [2:0] r_free_cnt;
    logic       r_rel_err;

    state_t     w_state_next;
    logic [1:0] w_sev_next;
    logic [1:0] w_id_next;
    logic [7:0] w_wait_next;
    logic       w_enq_valid_next;
    logic [3:0] w_enq_data_next;
    logic [3:0] w_busy_next;
    logic [2:0] w_busy_pop;
    logic [2:0] w_free_next;
    logic       w_rel_err_next;

    logic       w_arr_ready;
    logic       w_accept;
    logic [1:0] w_alloc_id;
    logic       w_rel_hit;
    logic [3:0] w_rel_mask;
    logic [3:0] w_alloc_mask;

    // Lowest-numbered free ID; scanning downward lets the smallest index win.
    always_comb begin
        w_alloc_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_alloc_id = 2'(i);
            end
        end
    end

    assign w_arr_ready = (r_state == S_IDLE) && (r_free_cnt != 3'd0);
    assign w_accept    = i_arr_valid && w_arr_ready;

    // Release and allocation both look at pre-edge busy bits, so an ID freed
    // this cycle cannot be handed out until the following edge.
    assign w_rel_hit    = i_rel_valid && r_busy[i_rel_id];
    assign w_rel_mask   = w_rel_hit ? (4'b0001 << i_rel_id) : 4'b0000;
    assign w_alloc_mask = w_accept ? (4'b0001 << w_alloc_id) : 4'b0000;
    assign w_busy_next  = (r_busy & ~w_rel_mask) | w_alloc_mask;

    assign w_busy_pop = {2'b00, w_busy_next[0]} + {2'b00, w_busy_next[1]}
                      + {2'b00, w_busy_next[2]} + {2'b00, w_busy_next[3]};
    assign w_free_next    = 3'd4 - w_busy_pop;
    assign w_rel_err_next = r_rel_err || (i_rel_valid && !r_busy[i_rel_id]);

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_sev_next       = r_sev;
        w_id_next        = r_id;
        w_wait_next      = r_wait_cnt;
        w_enq_valid_next = 1'b0;
        w_enq_data_next  = r_enq_data;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_HOLD;
                    w_sev_next   = i_arr_sev;
                    w_id_next    = w_alloc_id;
                    w_wait_next  = 8'd0;
                end
            end
            S_HOLD: begin
                if (!i_q_full) begin
                    w_enq_valid_next = 1'b1;
                    w_enq_data_next  = {r_sev, r_id};
                    w_state_next     = S_IDLE;
                end else if (r_wait_cnt == AGE_LAST) begin
                    w_wait_next = 8'd0;
                    w_sev_next  = (r_sev == 2'd3) ? 2'd3 : r_sev + 2'd1;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sev       <= 2'd0;
            r_id        <= 2'd0;
            r_wait_cnt  <= 8'd0;
            r_enq_valid <= 1'b0;
            r_enq_data  <= 4'd0;
            r_busy      <= 4'd0;
            r_free_cnt  <= 3'd4;
            r_rel_err   <= 1'b0;
        end else begin
            r_sev       <= w_sev_next;
            r_id        <= w_id_next;
            r_wait_cnt  <= w_wait_next;
            r_enq_valid <= w_enq_valid_next;
            r_enq_data  <= w_enq_data_next;
            r_busy      <= w_busy_next;
            r_free_cnt  <= w_free_next;
            r_rel_err   <= w_rel_err_next;
        end
    end

    assign o_arr_ready = w_arr_ready;
    assign o_enq_valid = r_enq_valid;
    assign o_enq_data  = r_enq_data;
    assign o_busy_ids  = r_busy;
    assign o_free_cnt  = r_free_cnt;
    assign o_rel_err   = r_rel_err;

endmodule

// File: tb/tb_patient_admit.sv
// Bench for patient_admit: directed scenarios plus random traffic, checked against
// a model that tracks a free-ID set and total stall count of the waiting token.
module tb_patient_admit;

    localparam int AGE = 4;

    logic       clk;
    logic       rst_n;
    logic       arr_valid;
    logic [1:0] arr_sev;
    logic       arr_ready;
    logic       q_full;
    logic       enq_valid;
    logic [3:0] enq_data;
    logic       rel_valid;
    logic [1:0] rel_id;
    logic [3:0] busy_ids;
    logic [2:0] free_cnt;
    logic       rel_err;

    int checks   = 0;
    int failures = 0;

    patient_admit #(.AGE_LIMIT(AGE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_arr_valid(arr_valid),
        .i_arr_sev  (arr_sev),
        .o_arr_ready(arr_ready),
        .i_q_full   (q_full),
        .o_enq_valid(enq_valid),
        .o_enq_data (enq_data),
        .i_rel_valid(rel_valid),
        .i_rel_id   (rel_id),
        .o_busy_ids (busy_ids),
        .o_free_cnt (free_cnt),
        .o_rel_err  (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of busy IDs, one optional waiting token whose
    // severity is its arrival severity plus one per AGE stalled edges (max 3).
    bit         m_busy [4];
    bit         m_hold;
    int         m_sev0;
    int         m_id;
    int         m_stall;
    logic       m_rel_err;
    logic       m_ev;
    logic [3:0] m_ed;

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 4; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] m_busy_vec();
        logic [3:0] v = 4'd0;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic m_ready();
        return !m_hold && (m_free() > 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
        m_hold    = 1'b0;
        m_sev0    = 0;
        m_id      = 0;
        m_stall   = 0;
        m_rel_err = 1'b0;
        m_ev      = 1'b0;
        m_ed      = 4'd0;
    endtask

    task automatic model_step();
        bit acc;
        int aid;
        int s;
        acc  = arr_valid && m_ready();
        aid  = m_lowest_free();
        m_ev = 1'b0;
        if (m_hold) begin
            if (!q_full) begin
                s = m_sev0 + m_stall / AGE;
                if (s > 3) s = 3;
                m_ev   = 1'b1;
                m_ed   = 4'(s * 4 + m_id);
                m_hold = 1'b0;
            end else begin
                m_stall++;
            end
        end
        if (rel_valid) begin
            if (m_busy[rel_id]) m_busy[rel_id] = 1'b0;
            else m_rel_err = 1'b1;
        end
        if (acc) begin
            m_busy[aid] = 1'b1;
            m_hold      = 1'b1;
            m_sev0      = int'(arr_sev);
            m_id        = aid;
            m_stall     = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".arr_ready"}, 8'(arr_ready), 8'(m_ready()));
        chk({tag, ".enq_valid"}, 8'(enq_valid), 8'(m_ev));
        chk({tag, ".enq_data"},  8'(enq_data),  8'(m_ed));
        chk({tag, ".busy_ids"},  8'(busy_ids),  8'(m_busy_vec()));
        chk({tag, ".free_cnt"},  8'(free_cnt),  8'(m_free()));
        chk({tag, ".rel_err"},   8'(rel_err),   8'(m_rel_err));
    endtask

    task automatic drive(input logic av, input logic [1:0] sv, input logic qf,
                         input logic rv, input logic [1:0] rid);
        arr_valid = av;
        arr_sev   = sv;
        q_full    = qf;
        rel_valid = rv;
        rel_id    = rid;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Accept one arrival, stall it for n edges on a full queue, then issue it.
    task automatic stall_and_issue(input logic [1:0] sev, input int n, input logic [3:0] exp_tok,
                                   input string tag);
        drive(1'b1, sev, 1'b1, 1'b0, 2'd0);
        tick();
        check_all({tag, ".acc"});
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, ".stall_ev"}, 8'(enq_valid), 8'd0);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all({tag, ".issue"});
        chk({tag, ".token"}, 8'(enq_data), 8'(exp_tok));
        drive(1'b0, 2'd0, 1'b0, 1'b1, exp_tok[1:0]);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy_ids",  8'(busy_ids),  8'h0);
        chk("rst.free_cnt",  8'(free_cnt),  8'h4);
        chk("rst.arr_ready", 8'(arr_ready), 8'h1);
        chk("rst.enq_valid", 8'(enq_valid), 8'h0);
        chk("rst.enq_data",  8'(enq_data),  8'h0);
        chk("rst.rel_err",   8'(rel_err),   8'h0);
        #3 rst_n = 1'b1;
        tick();
        check_all("idle");

        // Single arrival, queue open.
        drive(1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("single.acc");
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("single.issue");
        chk("single.enq_valid", 8'(enq_valid), 8'h1);
        chk("single.enq_data",  8'(enq_data),  8'b1000);
        chk("single.busy_ids",  8'(busy_ids),  8'b0001);
        chk("single.free_cnt",  8'(free_cnt),  8'h3);
        tick();
        check_all("single.after");
        chk("single.one_cycle", 8'(enq_valid), 8'h0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
        tick();
        check_all("single.rel");

        // ID exhaustion: sev s lands on ID s, giving token {s, s}.
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 1'b0, 1'b0, 2'd0);
            tick();
            check_all("exh.acc");
            drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
            tick();
            check_all("exh.issue");
            chk("exh.token", 8'(enq_data), 8'(s * 5));
        end
        chk("exh.ready_low", 8'(arr_ready), 8'h0);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("exh.stalled");
        chk("exh.busy_full", 8'(busy_ids), 8'hF);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
        tick();
        check_all("exh.rel2");
        chk("exh.ready_back", 8'(arr_ready), 8'h1);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("exh.reuse");
        chk("exh.token_0110", 8'(enq_data), 8'b0110);

        // Simultaneous arrival and release of ID 0 while all IDs are busy.
        drive(1'b1, 2'd0, 1'b0, 1'b1, 2'd0);
        tick();
        check_all("sim.same_edge");
        chk("sim.busy_1110", 8'(busy_ids), 8'b1110);
        drive(1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("sim.next_edge");
        chk("sim.busy_1111", 8'(busy_ids), 8'b1111);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("sim.issue");
        chk("sim.token_id0", 8'(enq_data), 8'b0000);

        // Drain, then release an ID that is already free.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b1, 2'(i));
            tick();
            check_all("drain");
        end
        chk("drain.rel_err_clear", 8'(rel_err), 8'h0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd1);
        tick();
        check_all("relerr");
        chk("relerr.set",  8'(rel_err),  8'h1);
        chk("relerr.busy", 8'(busy_ids), 8'h0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        chk("relerr.sticky", 8'(rel_err), 8'h1);

        // q_full pulse between edges must be ignored.
        drive(1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        #3 q_full = 1'b0;
        tick();
        check_all("glitch");
        chk("glitch.issued", 8'(enq_valid), 8'h1);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);

        // Aging boundaries with AGE_LIMIT=4.
        stall_and_issue(2'd1, 3,  4'b0100, "age3");
        stall_and_issue(2'd1, 4,  4'b1000, "age4");
        stall_and_issue(2'd1, 8,  4'b1100, "age8");
        stall_and_issue(2'd1, 10, 4'b1100, "age10");
        stall_and_issue(2'd3, 5,  4'b1100, "agesat");

        // Async reset pulsed between edges while a token waits.
        drive(1'b1, 2'd3, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        tick();
        check_all("arst.hold");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy_ids",  8'(busy_ids),  8'h0);
        chk("arst.free_cnt",  8'(free_cnt),  8'h4);
        chk("arst.arr_ready", 8'(arr_ready), 8'h1);
        chk("arst.rel_err",   8'(rel_err),   8'h0);
        model_reset();
        #2 rst_n = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("arst.no_issue");
            chk("arst.ev_low", 8'(enq_valid), 8'h0);
        end
        drive(1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        check_all("arst.resume");
        chk("arst.resume_tok", 8'(enq_data), 8'b1000);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)));
            tick();
            check_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
